knn_dist_seq: RTL

KNN_DIST_SEQ -- requirements
Module: knn_dist_seq

---
 rtl/knn_dist_seq.sv | 122 ++++++++++++
 1 files changed

// File: rtl/knn_dist_seq.sv
// Sequential vector distance unit: squared Euclidean or Manhattan distance,
// one dimension per cycle through a single shared term unit.
module knn_dist_seq #(
  parameter  int CW  = 16,
  parameter  int DIM = 2,
  localparam int OW  = 2*CW + $clog2(DIM)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [DIM*CW-1:0] in_a,
  input  logic [DIM*CW-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OW-1:0]     out_dist,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // CALC  | adding one dimension term per cycle
  // HOLD  | result presented until consumer accepts
  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_e;

  localparam int IW = $clog2(DIM) + 1;

  state_e              state_q;
  logic [DIM*CW-1:0]   a_q, b_q;
  logic                mode_q;
  logic [IW-1:0]       idx_q;
  logic [OW-1:0]       acc_q, acc_d;
  logic [OW-1:0]       dist_q;
  logic                in_ready_q, out_valid_q, busy_q;

  logic [CW-1:0]       a_sel, b_sel;
  logic [CW:0]         diff, neg_diff;
  logic [CW-1:0]       abs_d;
  logic [2*CW-1:0]     sq;
  logic [OW-1:0]       term;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < DIM; i++) begin
      if (idx_q == IW'(i)) begin
        a_sel = a_q[i*CW +: CW];
        b_sel = b_q[i*CW +: CW];
      end
    end
    // sign-extend by one bit so the difference can never overflow
    diff     = {a_sel[CW-1], a_sel} - {b_sel[CW-1], b_sel};
    neg_diff = -diff;
    abs_d    = diff[CW] ? neg_diff[CW-1:0] : diff[CW-1:0];
    sq       = {{CW{1'b0}}, abs_d} * {{CW{1'b0}}, abs_d};
    term     = mode_q ? OW'(abs_d) : OW'(sq);
    acc_d    = acc_q + term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      idx_q       <= '0;
      acc_q       <= '0;
      dist_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            mode_q     <= in_mode;
            acc_q      <= '0;
            idx_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (idx_q == IW'(DIM-1)) begin
            dist_q      <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            dist_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          dist_q      <= '0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_dist  = dist_q;

endmodule
